// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit and its datapath.
// Holds opcode values, FSM state codes, datapath mux select codes and the
// control-word struct that the output decoder produces.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SEL_W    = 2;

    // Supported opcodes (instruction bits [31:26])
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    // FSM state encodings
    localparam logic [STATE_W-1:0] S_FETCH     = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE    = 4'd1;
    localparam logic [STATE_W-1:0] S_MEM_ADDR  = 4'd2;
    localparam logic [STATE_W-1:0] S_MEM_READ  = 4'd3;
    localparam logic [STATE_W-1:0] S_MEM_WB    = 4'd4;
    localparam logic [STATE_W-1:0] S_MEM_WRITE = 4'd5;
    localparam logic [STATE_W-1:0] S_EXECUTE   = 4'd6;
    localparam logic [STATE_W-1:0] S_R_WB      = 4'd7;
    localparam logic [STATE_W-1:0] S_BRANCH    = 4'd8;
    localparam logic [STATE_W-1:0] S_JUMP      = 4'd9;
    localparam logic [STATE_W-1:0] S_ADDI_EXEC = 4'd10;
    localparam logic [STATE_W-1:0] S_ADDI_WB   = 4'd11;

    // ALU B input select
    localparam logic [SEL_W-1:0] ALUB_REG     = 2'b00;
    localparam logic [SEL_W-1:0] ALUB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] ALUB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] ALUB_IMM_SH2 = 2'b11;

    // ALU operation select
    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // Full control word driven toward the datapath
    typedef struct packed {
        logic             pc_write;
        logic             pc_write_cond;
        logic             i_or_d;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             mem_to_reg;
        logic             reg_dst;
        logic             reg_write;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] pc_source;
        logic             illegal_op;
    } ctrl_word_t;

    // True for every opcode the FSM knows how to sequence
    function automatic logic op_supported(input logic [OPCODE_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)   || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_ctrl_output_decode.sv
// Moore output decoder: maps the current FSM state to the control word.
// Ports:
//   state_i  - current FSM state
//   opcode_i - instruction opcode, used only to flag illegal_op in DECODE
//   ctrl_c   - combinational control word
module mips_ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic [STATE_W-1:0]  state_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_word_t          ctrl_c
);

    // Unlisted fields stay 0; unreachable codes fall through to all-zero
    always_comb begin
        ctrl_c = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.ir_write  = 1'b1;
                ctrl_c.alu_src_b = ALUB_FOUR;
                ctrl_c.alu_op    = ALUOP_ADD;
                ctrl_c.pc_source = PCSRC_ALU;
                ctrl_c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Speculative branch target computation
                ctrl_c.alu_src_b  = ALUB_IMM_SH2;
                ctrl_c.alu_op     = ALUOP_ADD;
                ctrl_c.illegal_op = !op_supported(opcode_i);
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = ALUB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = ALUB_REG;
                ctrl_c.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a     = 1'b1;
                ctrl_c.alu_src_b     = ALUB_REG;
                ctrl_c.alu_op        = ALUOP_SUB;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl_c.reg_write = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM. Holds the state register and next-state
// logic; the control word comes from mips_ctrl_output_decode. All outputs,
// including the debug state, are forced to 0 while reset is high.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   opcode            - IR[31:26]
//   pc_write .. illegal_op - datapath enables, strobes and mux selects
//   state             - current state for debug
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [SEL_W-1:0]    alu_op,
    output logic [SEL_W-1:0]    pc_source,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_word_t         ctrl_c;
    ctrl_word_t         ctrl_gated;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; opcode only matters in DECODE and MEM_ADDR
    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                // Anything other than lw/sw here aborts to FETCH safely
                if (opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_READ:  state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = S_FETCH;
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    mips_ctrl_output_decode u_output_decode (
        .state_i  (state_q),
        .opcode_i (opcode),
        .ctrl_c   (ctrl_c)
    );

    // Reset gating: no strobe can leak out during the reset cycle
    assign ctrl_gated = reset ? '0 : ctrl_c;
    assign state      = reset ? '0 : state_q;

    assign pc_write      = ctrl_gated.pc_write;
    assign pc_write_cond = ctrl_gated.pc_write_cond;
    assign i_or_d        = ctrl_gated.i_or_d;
    assign mem_read      = ctrl_gated.mem_read;
    assign mem_write     = ctrl_gated.mem_write;
    assign ir_write      = ctrl_gated.ir_write;
    assign mem_to_reg    = ctrl_gated.mem_to_reg;
    assign reg_dst       = ctrl_gated.reg_dst;
    assign reg_write     = ctrl_gated.reg_write;
    assign alu_src_a     = ctrl_gated.alu_src_a;
    assign alu_src_b     = ctrl_gated.alu_src_b;
    assign alu_op        = ctrl_gated.alu_op;
    assign pc_source     = ctrl_gated.pc_source;
    assign illegal_op    = ctrl_gated.illegal_op;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: a vector table walks every
// instruction class cycle by cycle, then hand sequences cover reset abort
// in MEM_READ and cycles-per-instruction for each opcode.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    // Observed word, MSB first:
    // pc_write pc_write_cond i_or_d mem_read mem_write ir_write mem_to_reg
    // reg_dst reg_write alu_src_a alu_src_b[2] alu_op[2] pc_source[2]
    // illegal_op state[4]
    logic [20:0] obs;
    assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, illegal_op, state};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000;
    localparam logic [5:0] IL = 6'b111111;

    //                           pw pwc iod mr mw irw m2r rd rw asa  asb   aop   ps   ill  state
    localparam logic [20:0] E_ZERO  = 21'd0;
    localparam logic [20:0] E_FETCH = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,4'd0};
    localparam logic [20:0] E_DEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,4'd1};
    localparam logic [20:0] E_DECIL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1,4'd1};
    localparam logic [20:0] E_MADDR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,4'd2};
    localparam logic [20:0] E_MREAD = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,4'd3};
    localparam logic [20:0] E_MWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,4'd4};
    localparam logic [20:0] E_MWR   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,4'd5};
    localparam logic [20:0] E_EXEC  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,4'd6};
    localparam logic [20:0] E_RWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,4'd7};
    localparam logic [20:0] E_BR    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,4'd8};
    localparam logic [20:0] E_JMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,4'd9};
    localparam logic [20:0] E_AEX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,4'd10};
    localparam logic [20:0] E_AWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,4'd11};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [5:0] o, input logic [20:0] e);
        vec_t v;
        v.rst = r;
        v.op  = o;
        v.exp = e;
        vecs.push_back(v);
    endtask

    // Compare observed word plus the mem_read/mem_write exclusion rule
    task automatic check(input string name, input logic [20:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", name, obs, exp);
        end
        total++;
        if (mem_read && mem_write) begin
            bad++;
            $display("FAIL %s mem_excl: got mem_read=1 mem_write=1 want not both", name);
        end
    endtask

    // Advance one cycle; leave time 1 after the edge for input changes
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from FETCH and count cycles until FETCH returns
    task automatic measure_cpi(input string name, input logic [5:0] op, input int exp_n);
        int n;
        opcode = op;
        n = 0;
        do begin
            step();
            n++;
        end while (state != 4'd0 && n < 12);
        total++;
        if (n != exp_n) begin
            bad++;
            $display("FAIL cpi_%s: got=%0d want=%0d", name, n, exp_n);
        end
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'b0;

        // Reset held 3 cycles, then one of each instruction class
        add(1, RT, E_ZERO);  add(1, RT, E_ZERO);  add(1, RT, E_ZERO);
        add(0, LW, E_FETCH); add(0, LW, E_DEC);   add(0, LW, E_MADDR);
        add(0, LW, E_MREAD); add(0, LW, E_MWB);
        add(0, SW, E_FETCH); add(0, SW, E_DEC);   add(0, SW, E_MADDR);
        add(0, SW, E_MWR);
        // R-type with opcode disturbed outside DECODE: no effect
        add(0, RT, E_FETCH); add(0, RT, E_DEC);   add(0, LW, E_EXEC);
        add(0, BQ, E_RWB);
        add(0, BQ, E_FETCH); add(0, BQ, E_DEC);   add(0, BQ, E_BR);
        add(0, JJ, E_FETCH); add(0, JJ, E_DEC);   add(0, JJ, E_JMP);
        add(0, AI, E_FETCH); add(0, AI, E_DEC);   add(0, AI, E_AEX);
        add(0, SW, E_AWB);
        add(0, IL, E_FETCH); add(0, IL, E_DECIL); add(0, IL, E_FETCH);
        add(0, 6'b010101, E_DECIL); add(0, LW, E_FETCH);

        #1;
        foreach (vecs[i]) begin
            reset  = vecs[i].rst;
            opcode = vecs[i].op;
            #2;
            check($sformatf("vec%0d", i), vecs[i].exp);
            step();
        end

        // Reset asserted in MEM_READ aborts the load
        reset = 1'b1; opcode = LW;
        step();
        reset = 1'b0;
        #2; check("lw_fetch", E_FETCH); step();
        #2; check("lw_dec",   E_DEC);   step();
        #2; check("lw_maddr", E_MADDR); step();
        #2; check("lw_mread", E_MREAD);
        reset = 1'b1;
        #2; check("rst_in_mread", E_ZERO); step();
        #2; check("rst_after_mread", E_ZERO);
        reset = 1'b0;
        #2; check("rst_release_fetch", E_FETCH); step();
        #2; check("after_abort_dec", E_DEC);
        opcode = IL;
        step();
        #2; check("after_abort_fetch", E_FETCH);

        // Cycles per instruction, each run starting in FETCH
        measure_cpi("lw",   LW, 5);
        measure_cpi("sw",   SW, 4);
        measure_cpi("rt",   RT, 4);
        measure_cpi("addi", AI, 4);
        measure_cpi("beq",  BQ, 3);
        measure_cpi("j",    JJ, 3);
        measure_cpi("ill",  IL, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
